// File: rtl/rst_seq_ctrl_pkg.sv
// ============================================================================
// Module   : rst_seq_ctrl_pkg
// Brief    : State encodings and default parameters for the reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        RSQ_ASSERT  = 2'd0,
        RSQ_HOLD    = 2'd1,
        RSQ_RELEASE = 2'd2,
        RSQ_RUN     = 2'd3
    } rsq_state_e;

    localparam int unsigned RSQ_SYNC_STAGES_DEF = 2;
    localparam int unsigned RSQ_HOLD_CYCLES_DEF = 16;
    localparam int unsigned RSQ_NUM_CH_DEF      = 3;
    localparam int unsigned RSQ_CH_GAP_DEF      = 4;

    function automatic int unsigned rsq_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rst_seq_ctrl_sync_chain.sv
// ============================================================================
// Module   : rst_sync_chain
// Brief    : STAGES-deep single-bit synchroniser with async active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
// ============================================================================
// Module   : rst_seq_ctrl
// Brief    : Reset synchroniser and sequencer releasing NUM_CH channels in order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = RSQ_SYNC_STAGES_DEF,
    parameter int unsigned HOLD_CYCLES = RSQ_HOLD_CYCLES_DEF,
    parameter int unsigned NUM_CH      = RSQ_NUM_CH_DEF,
    parameter int unsigned CH_GAP      = RSQ_CH_GAP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              soft_rst_req,
    output logic [NUM_CH-1:0] ch_rst_o,
    output logic              all_released,
    output logic [1:0]        state_o
);

    localparam int unsigned CNT_W = $clog2(rsq_max(HOLD_CYCLES, CH_GAP)) + 1;
    localparam int unsigned IDX_W = $clog2(NUM_CH) + 1;

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(CH_GAP - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_CH - 1);

    logic rst_s;
    logic lock_s;

    rst_sync_chain #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (1'b1),
        .q     (rst_s)
    );

    rst_sync_chain #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (pll_locked),
        .q     (lock_s)
    );

    rsq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
    logic              all_rel_q, all_rel_d;
    logic [NUM_CH-1:0] release_mask;

    always_comb begin
        release_mask = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            release_mask[i] = (IDX_W'(i) == idx_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        ch_rst_d  = ch_rst_q;
        all_rel_d = all_rel_q;

        case (state_q)
            RSQ_ASSERT: begin
                ch_rst_d  = '1;
                all_rel_d = 1'b0;
                cnt_d     = '0;
                idx_d     = '0;
                if (rst_s && lock_s) begin
                    state_d = RSQ_HOLD;
                end
            end
            RSQ_HOLD: begin
                if (cnt_q == C_HOLD_LAST) begin
                    ch_rst_d[0] = 1'b0;
                    cnt_d       = '0;
                    idx_d       = IDX_W'(1);
                    if (NUM_CH == 1) begin
                        state_d   = RSQ_RUN;
                        all_rel_d = 1'b1;
                    end else begin
                        state_d   = RSQ_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RSQ_RELEASE: begin
                if (cnt_q == C_GAP_LAST) begin
                    ch_rst_d = ch_rst_q & ~release_mask;
                    cnt_d    = '0;
                    idx_d    = idx_q + IDX_W'(1);
                    if (idx_q == C_IDX_LAST) begin
                        state_d   = RSQ_RUN;
                        all_rel_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase

        // Lock loss outranks a concurrent soft request.
        if (state_q != RSQ_ASSERT) begin
            if (!lock_s) begin
                state_d   = RSQ_ASSERT;
                ch_rst_d  = '1;
                all_rel_d = 1'b0;
                cnt_d     = '0;
                idx_d     = '0;
            end else if (soft_rst_req) begin
                state_d   = RSQ_HOLD;
                ch_rst_d  = '1;
                all_rel_d = 1'b0;
                cnt_d     = '0;
                idx_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RSQ_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            ch_rst_q  <= '1;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ch_rst_q  <= ch_rst_d;
            all_rel_q <= all_rel_d;
        end
    end

    assign ch_rst_o     = ch_rst_q;
    assign all_released = all_rel_q;
    assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// ============================================================================
// Module   : tb_rst_seq_ctrl
// Brief    : Directed self-checking bench for rst_seq_ctrl (default and minimal params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst, pll_locked, soft_rst_req;
    logic [2:0] ch_rst_o;
    logic       all_released;
    logic [1:0] state_o;

    logic       rst2, pll2, soft2;
    logic [0:0] ch2;
    logic       all2;
    logic [1:0] state2;

    int checks = 0;
    int errors = 0;

    rst_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .ch_rst_o     (ch_rst_o),
        .all_released (all_released),
        .state_o      (state_o)
    );

    rst_seq_ctrl #(
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1),
        .NUM_CH      (1),
        .CH_GAP      (1)
    ) dut_min (
        .clk          (clk),
        .rst          (rst2),
        .pll_locked   (pll2),
        .soft_rst_req (soft2),
        .ch_rst_o     (ch2),
        .all_released (all2),
        .state_o      (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs at edge e of a sequence started with lock already steady.
    function automatic logic [2:0] exp_ch(input int e);
        return (e < 19) ? 3'b111 : (e < 23) ? 3'b110 : (e < 27) ? 3'b100 : 3'b000;
    endfunction
    function automatic logic [1:0] exp_state(input int e);
        return (e <= 2) ? 2'd0 : (e < 19) ? 2'd1 : (e < 27) ? 2'd2 : 2'd3;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (!(ch_rst_o inside {3'b111, 3'b110, 3'b100, 3'b000})) begin
                errors++;
                $display("FAIL monotonic_release: ch_rst_o=%b", ch_rst_o);
            end
            if (all_released !== (ch_rst_o == 3'b000)) begin
                errors++;
                $display("FAIL all_released_consistency: all_released=%b ch_rst_o=%b", all_released, ch_rst_o);
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0; pll_locked = 1'b1; soft_rst_req = 1'b0;
        repeat (5) tick();
        checks++; if (ch_rst_o !== 3'b111) begin errors++; $display("FAIL reset_ch: got %b exp 111", ch_rst_o); end
        checks++; if (all_released !== 1'b0) begin errors++; $display("FAIL reset_all: got %b exp 0", all_released); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_o); end
    endtask

    task automatic test_power_on;
        rst = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            tick();
            checks++; if (ch_rst_o !== exp_ch(e)) begin errors++; $display("FAIL pwr_ch e=%0d: got %b exp %b", e, ch_rst_o, exp_ch(e)); end
            checks++; if (state_o !== exp_state(e)) begin errors++; $display("FAIL pwr_state e=%0d: got %0d exp %0d", e, state_o, exp_state(e)); end
            checks++; if (all_released !== (e >= 27)) begin errors++; $display("FAIL pwr_all e=%0d: got %b exp %b", e, all_released, (e >= 27)); end
        end
    endtask

    task automatic test_late_lock;
        rst = 1'b0; pll_locked = 1'b0;
        tick();
        rst = 1'b1;
        repeat (10) tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL soft_in_assert_state: got %0d exp 0", state_o); end
        checks++; if (ch_rst_o !== 3'b111) begin errors++; $display("FAIL soft_in_assert_ch: got %b exp 111", ch_rst_o); end
        pll_locked = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            tick();
            checks++; if (ch_rst_o !== exp_ch(e)) begin errors++; $display("FAIL lock_ch e=%0d: got %b exp %b", e, ch_rst_o, exp_ch(e)); end
            checks++; if (state_o !== exp_state(e)) begin errors++; $display("FAIL lock_state e=%0d: got %0d exp %0d", e, state_o, exp_state(e)); end
        end
    endtask

    task automatic test_lock_loss;
        pll_locked = 1'b0;
        tick();
        checks++; if (ch_rst_o !== 3'b000) begin errors++; $display("FAIL loss_edge0_ch: got %b exp 000", ch_rst_o); end
        pll_locked = 1'b1;
        tick();
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL loss_edge1_state: got %0d exp 3", state_o); end
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        checks++; if (ch_rst_o !== 3'b111) begin errors++; $display("FAIL loss_ch: got %b exp 111", ch_rst_o); end
        checks++; if (all_released !== 1'b0) begin errors++; $display("FAIL loss_all: got %b exp 0", all_released); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL loss_beats_soft_state: got %0d exp 0", state_o); end
        for (int e = 3; e <= 27; e++) begin
            tick();
            checks++; if (ch_rst_o !== exp_ch(e)) begin errors++; $display("FAIL relock_ch e=%0d: got %b exp %b", e, ch_rst_o, exp_ch(e)); end
            checks++; if (state_o !== exp_state(e)) begin errors++; $display("FAIL relock_state e=%0d: got %0d exp %0d", e, state_o, exp_state(e)); end
        end
    endtask

    task automatic test_soft_reset;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (19) tick();
        checks++; if (ch_rst_o !== 3'b110) begin errors++; $display("FAIL soft_pre_ch: got %b exp 110", ch_rst_o); end
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        checks++; if (ch_rst_o !== 3'b111) begin errors++; $display("FAIL soft_ch: got %b exp 111", ch_rst_o); end
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL soft_state: got %0d exp 1", state_o); end
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++; if (ch_rst_o !== 3'b111) begin errors++; $display("FAIL soft_hold_ch k=%0d: got %b exp 111", k, ch_rst_o); end
        end
        tick();
        checks++; if (ch_rst_o !== 3'b110) begin errors++; $display("FAIL soft_release_ch: got %b exp 110", ch_rst_o); end
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL soft_release_state: got %0d exp 2", state_o); end
    endtask

    task automatic test_async_reset;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (10) tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL async_pre_state: got %0d exp 1", state_o); end
        #2 rst = 1'b0;
        #1;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL async_hold_state: got %0d exp 0", state_o); end
        checks++; if (ch_rst_o !== 3'b111) begin errors++; $display("FAIL async_hold_ch: got %b exp 111", ch_rst_o); end
        tick();
        rst = 1'b1;
        repeat (27) tick();
        checks++; if (ch_rst_o !== 3'b000) begin errors++; $display("FAIL async_pre_run_ch: got %b exp 000", ch_rst_o); end
        #2 rst = 1'b0;
        #1;
        checks++; if (ch_rst_o !== 3'b111) begin errors++; $display("FAIL async_run_ch: got %b exp 111", ch_rst_o); end
        checks++; if (all_released !== 1'b0) begin errors++; $display("FAIL async_run_all: got %b exp 0", all_released); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL async_run_state: got %0d exp 0", state_o); end
    endtask

    task automatic test_min_params;
        checks++; if (ch2 !== 1'b1) begin errors++; $display("FAIL min_reset_ch: got %b exp 1", ch2); end
        rst2 = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++; if (ch2 !== (e < 5)) begin errors++; $display("FAIL min_ch e=%0d: got %b exp %b", e, ch2, (e < 5)); end
            checks++; if (all2 !== (e >= 5)) begin errors++; $display("FAIL min_all e=%0d: got %b exp %b", e, all2, (e >= 5)); end
        end
        checks++; if (state2 !== 2'd3) begin errors++; $display("FAIL min_state: got %0d exp 3", state2); end
    endtask

    initial begin
        rst = 1'b0; pll_locked = 1'b1; soft_rst_req = 1'b0;
        rst2 = 1'b0; pll2 = 1'b1; soft2 = 1'b0;
        test_reset();
        test_power_on();
        test_late_lock();
        test_lock_loss();
        test_soft_reset();
        test_async_reset();
        test_min_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
